segasys1_sndreq_rx: RTL
=======================

Name: segasys1_sndreq_rx

Overview:
Receiving end of the main-CPU sound request interface, sitting in front of the System 1 sound Z80.
- Captures each one-cycle SNDRQ/SNDNO strobe from the main board into a command latch.
- Raises a timed NMI to the sound CPU and serves the latch on sound-CPU reads of $E000-$FFFF.
- Generates the periodic sound IRQ (4 per frame) with Z80 interrupt-acknowledge clearing.

Parameters:
NMI_LEN, 8, NMI high time in sound-CPU clock enables (1..255).
IRQ_PERIOD, 16667, sound-CPU clock enables between IRQ assertions (>=2, fits 16 bits).
FIFO_DEPTH, 4, command queue depth; power of two; used only with SEGASYS1_SNDQ_FIFO_EN.

Ports:
CLK48M  input  1  system clock; all state on rising edge.
RESET_N  input  1  asynchronous active-low reset.
SNDRQ  input  1  one-CLK48M-cycle write strobe from main CPU side.
SNDNO  input  8  command byte, valid while SNDRQ=1.
SCPU_CLKEN  input  1  sound-CPU clock enable.
SCPUAD  input  16  sound-CPU address.
SCPU_MREQ  input  1  sound-CPU memory request, active high.
SCPU_IORQ  input  1  sound-CPU IO request, active high.
SCPU_RD  input  1  sound-CPU read, active high.
SCPU_M1  input  1  sound-CPU M1, active high.
SLCS  output  1  latch selected; combinational: SCPUAD[15:13]==3'b111 & SCPU_MREQ & SCPU_RD.
SLDO  output  8  latch read data; current command when SLCS, else 8'hFF.
SNMI  output  1  NMI request to sound CPU, active high.
SIRQ  output  1  INT request to sound CPU, active high, level.
PENDING  output  1  unread command present.
OVF  output  1  sticky queue overflow; constant 0 without the optional feature.

Behaviour:
Reset (RESET_N low, async), all registers cleared:
- SNMI=0, SIRQ=0, PENDING=0, OVF=0, command=8'h00, SLDO=8'hFF.
- NMI counter=0; IRQ counter=0.

Capture:
- On a CLK48M edge with SNDRQ=1: command<=SNDNO, PENDING<=1, NMI counter<=NMI_LEN.
- Capture does not depend on SCPU_CLKEN; single-cycle strobe is never missed.

NMI:
- SNMI = (NMI counter != 0), registered.
- Counter decrements on each SCPU_CLKEN while nonzero.
- SNDRQ while the counter is nonzero overwrites the latch and reloads the counter; SNMI has no low gap.

Read/clear:
- PENDING clears on the edge where SLCS & SCPU_CLKEN.
- SNDRQ on that same edge wins: new data latched, PENDING stays 1, NMI restarts.
- A read with PENDING=0 returns the stale command with no side effects.

IRQ:
- Counter increments on SCPU_CLKEN and wraps IRQ_PERIOD-1 -> 0.
- Wrap sets SIRQ=1.
- SIRQ clears on SCPU_M1 & SCPU_IORQ & SCPU_CLKEN (interrupt acknowledge).
- Wrap while SIRQ=1 leaves it set (no queuing).
- Wrap coinciding with an acknowledge leaves SIRQ=1.

Reset mid-operation: asynchronously aborts any NMI pulse, pending command and IRQ.

Optional Feature:
SEGASYS1_SNDQ_FIFO_EN, defined:
- Commands go into a FIFO_DEPTH-entry queue; SLDO shows the head.
- A read-clear pops the head; PENDING = queue non-empty.
- After a pop leaving the queue non-empty, the NMI counter reloads NMI_LEN.
- Push into a full queue drops the new byte and sets OVF until reset.
- Simultaneous push and pop on a full queue: pop then push, no overflow.

SEGASYS1_SNDQ_FIFO_EN, undefined:
- Single overwrite latch as above; OVF tied 0.

Decomposition:
Package segasys1_snd_pkg holds:
- latch decode constant 3'b111 for SCPUAD[15:13];
- command width 8;
- default NMI_LEN and IRQ_PERIOD values.

One sub-module, segasys1_cmd_fifo (synchronous FIFO with push, pop, head, empty, full), is instantiated only under the macro.

Test Plan:
1. Reset release, no activity -> SNMI=0, PENDING=0, SLDO=8'hFF; SIRQ rises after exactly 16667 SCPU_CLKENs.
2. SNDRQ with SNDNO=8'h5A -> SNMI high for 8 SCPU_CLKENs; read at $E000 gives SLDO=8'h5A; PENDING falls on the read's SCPU_CLKEN edge.
3. SNDRQ 8'h11, then 8'h22 after 3 enables -> SNMI stays high for 3+8 enables; read returns 8'h22.
4. SNDRQ 8'h33 on the same edge as a read-clear -> PENDING stays 1; SLDO=8'h33; NMI restarts at 8.
5. SIRQ set, M1+IORQ acknowledge with SCPU_CLKEN -> SIRQ=0 next edge; acknowledge on a wrap edge -> SIRQ remains 1.
6. FIFO_EN: push 8'h01..8'h05 with depth 4 -> OVF=1; four reads return 01, 02, 03, 04 with an NMI after each pop except the last; PENDING=0 at end.

Source files
------------

// File: rtl/segasys1_snd_pkg.sv
// segasys1_snd_pkg: shared constants for the System 1 sound request receiver.
package segasys1_snd_pkg;
    localparam int         CMD_W          = 8;
    localparam logic [2:0] LATCH_DEC      = 3'b111;
    localparam int         NMI_LEN_DEF    = 8;
    localparam int         IRQ_PERIOD_DEF = 16667;
endpackage

// File: rtl/segasys1_cmd_fifo.sv
// segasys1_cmd_fifo: synchronous command queue; a pop and a push on a full queue both take effect.
module segasys1_cmd_fifo
    import segasys1_snd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr, rd;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign head  = mem_q[rp_q];
    assign count = cnt_q;

    always_comb begin
        rd    = pop & ~empty;
        wr    = push & (~full | pop);
        mem_d = mem_q;
        if (wr) mem_d[wp_q] = din;
        wp_d  = wr ? wp_q + 1'b1 : wp_q;
        rp_d  = rd ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/segasys1_sndreq_rx.sv
// segasys1_sndreq_rx: sound-side command latch, timed NMI and periodic IRQ for the sound Z80.
// Define SEGASYS1_SNDQ_FIFO_EN to replace the overwrite latch with a FIFO_DEPTH command queue.
module segasys1_sndreq_rx
    import segasys1_snd_pkg::*;
#(
    parameter int NMI_LEN    = NMI_LEN_DEF,
    parameter int IRQ_PERIOD = IRQ_PERIOD_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             CLK48M,
    input  logic             RESET_N,
    input  logic             SNDRQ,
    input  logic [CMD_W-1:0] SNDNO,
    input  logic             SCPU_CLKEN,
    input  logic [15:0]      SCPUAD,
    input  logic             SCPU_MREQ,
    input  logic             SCPU_IORQ,
    input  logic             SCPU_RD,
    input  logic             SCPU_M1,
    output logic             SLCS,
    output logic [CMD_W-1:0] SLDO,
    output logic             SNMI,
    output logic             SIRQ,
    output logic             PENDING,
    output logic             OVF
);
    logic [7:0]       nmi_q, nmi_d;
    logic [15:0]      irq_q, irq_d;
    logic             sirq_q, sirq_d;
    logic [CMD_W-1:0] cmd;
    logic             rd_clr, reload, wrap, ack;
    logic             unused_ok;

    assign unused_ok = ^{SCPUAD[12:0], FIFO_DEPTH[0]};
    assign SLCS      = (SCPUAD[15:13] == LATCH_DEC) & SCPU_MREQ & SCPU_RD;
    assign SLDO      = SLCS ? cmd : '1;
    assign rd_clr    = SLCS & SCPU_CLKEN;
    assign SNMI      = nmi_q != '0;
    assign SIRQ      = sirq_q;

`ifdef SEGASYS1_SNDQ_FIFO_EN
    localparam int QW = $clog2(FIFO_DEPTH);

    logic          empty, full, pop, ovf_q, ovf_d;
    logic [QW:0]   count;

    segasys1_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK48M),
        .rst_n (RESET_N),
        .push  (SNDRQ),
        .pop   (pop),
        .din   (SNDNO),
        .head  (cmd),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    // A pop that leaves work behind re-announces the new head to the sound CPU.
    always_comb begin
        pop    = rd_clr & ~empty;
        reload = SNDRQ | (pop & (count != (QW+1)'(1)));
        ovf_d  = ovf_q | (SNDRQ & full & ~pop);
    end

    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign PENDING = ~empty;
    assign OVF     = ovf_q;
`else
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             pend_q, pend_d;

    always_comb begin
        cmd_d  = SNDRQ ? SNDNO : cmd_q;
        pend_d = SNDRQ | (pend_q & ~rd_clr);
        reload = SNDRQ;
    end

    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            pend_q <= pend_d;
        end
    end

    assign cmd     = cmd_q;
    assign PENDING = pend_q;
    assign OVF     = 1'b0;
`endif

    always_comb begin
        nmi_d  = reload ? 8'(NMI_LEN) : (SCPU_CLKEN && nmi_q != '0) ? nmi_q - 1'b1 : nmi_q;
        wrap   = SCPU_CLKEN & (irq_q == 16'(IRQ_PERIOD - 1));
        irq_d  = wrap ? '0 : SCPU_CLKEN ? irq_q + 1'b1 : irq_q;
        ack    = SCPU_M1 & SCPU_IORQ & SCPU_CLKEN;
        sirq_d = wrap | (sirq_q & ~ack);
    end

    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            nmi_q  <= '0;
            irq_q  <= '0;
            sirq_q <= 1'b0;
        end else begin
            nmi_q  <= nmi_d;
            irq_q  <= irq_d;
            sirq_q <= sirq_d;
        end
    end
endmodule
